// File: rtl/div.sv
// rtl/div.sv - Iterative restoring 32-bit signed/unsigned divider for the EX stage.
// Produces {remainder, quotient}; holds ready_o until the request is withdrawn.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   dvd, dvd_nxt;
  logic [DATA_W-1:0]   dvs, dvs_nxt;
  logic [DATA_W-1:0]   rem, rem_nxt;
  logic                neg_q, neg_q_nxt;
  logic                neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  logic [DATA_W:0]     shifted, diff;
  logic [DATA_W-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic                a_neg, b_neg, ge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dvd      <= dvd_nxt;
      dvs      <= dvs_nxt;
      rem      <= rem_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result_o;
    ready_nxt  = ready_o;

    a_neg = signed_div_i & opdata1_i[DATA_W-1];
    b_neg = signed_div_i & opdata2_i[DATA_W-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;

    // Partial remainder needs one extra bit: it can reach 2*divisor-1 after the shift.
    shifted = {rem, dvd[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = ~diff[DATA_W];

    q_fix = neg_q ? -dvd : dvd;
    r_fix = neg_r ? -rem : rem;

    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          dvd_nxt   = a_mag;
          dvs_nxt   = b_mag;
          neg_q_nxt = a_neg ^ b_neg;
          neg_r_nxt = a_neg;
          cnt_nxt   = '0;
          rem_nxt   = '0;
          state_nxt = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        dvd_nxt   = '0;
        rem_nxt   = '0;
        state_nxt = END;
      end
      ON: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          rem_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
          dvd_nxt = {dvd[DATA_W-2:0], ge};
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state_nxt = END;
        end
      end
      END: begin
        if (!ready_o) begin
          result_nxt = {r_fix, q_fix};
          ready_nxt  = 1'b1;
        end else if (!start_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
          state_nxt  = FREE;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - Directed self-checking bench for div.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // n = number of edges after the sampling edge E0 at which ready_o was first seen
  task automatic wait_ready(output int n);
    logic s0;
    s0 = signed_div_i;
    n = -1;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 0) begin
        opdata1_i    = ~opdata1_i;
        opdata2_i    = 32'h0000_0005;
        signed_div_i = ~s0;
      end
    end while (!ready_o && n < 100);
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    start_op(s, a, b);
    wait_ready(n);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_result"}, result_o, exp);
    @(posedge clk); #1;
    chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_result"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int  n;
    logic saw;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    #3;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run("u_100_7",    1'b0, 32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, 33);
    run("s_m100_7",   1'b1, 32'hFFFF_FF9C, 32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    run("u_max_2",    1'b0, 32'hFFFF_FFFF, 32'd2,        {32'h0000_0001, 32'h7FFF_FFFF}, 33);
    run("s_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33);
    run("s_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run("u_div0",     1'b0, 32'd12345,     32'd0,        64'd0, 2);
    run("s_div0",     1'b1, 32'hFFFF_FFFB, 32'd0,        64'd0, 2);
    run("s_m7_m2",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, 33);

    // Flush during ON after ten steps
    start_op(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) saw = 1'b1;
    end
    chk("annul_no_ready", 64'(saw), 64'd0);
    run("after_annul", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);

    // Async reset during ON
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_on_ready", 64'(ready_o), 64'd0);
    chk("rst_on_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst_on", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33);

    // Async reset while the result is being held
    start_op(1'b0, 32'd1000, 32'd3);
    wait_ready(n);
    chk("rst_end_pre_ready", 64'(ready_o), 64'd1);
    chk("rst_end_pre_result", result_o, {32'h0000_0001, 32'h0000_014D});
    #2;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst_end", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
